// File: rtl/param_cpu.sv
// Parameterised multi-cycle CPU: eight DW-bit registers, FETCH/EXEC/MEM/HALT control
// and a request/acknowledge memory port used by LD and ST.
module param_cpu #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   IR,
  input  logic          ir_valid,
  output logic [AW-1:0] PC,
  input  logic [DW-1:0] Data_in,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic          MW,
  output logic [AW-1:0] Address_out,
  output logic [DW-1:0] Data_out,
  output logic [3:0]    flags,
  output logic          halted
);
  localparam logic [6:0] OP_MOVA = 7'b0000000, OP_INC  = 7'b0000001, OP_ADD  = 7'b0000010;
  localparam logic [6:0] OP_SUB  = 7'b0000101, OP_DEC  = 7'b0000110, OP_AND  = 7'b0001000;
  localparam logic [6:0] OP_OR   = 7'b0001001, OP_XOR  = 7'b0001010, OP_NOT  = 7'b0001011;
  localparam logic [6:0] OP_MOVB = 7'b0001100, OP_SHR  = 7'b0001101, OP_SHL  = 7'b0001110;
  localparam logic [6:0] OP_LDI  = 7'b1001100, OP_ADI  = 7'b1000010, OP_LD   = 7'b0010000;
  localparam logic [6:0] OP_ST   = 7'b0100000, OP_BRZ  = 7'b1100000, OP_BRN  = 7'b1100001;
  localparam logic [6:0] OP_JMP  = 7'b1110000, OP_HALT = 7'b1111111;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   ir_q, ir_d;
  logic [3:0]    flags_q, flags_d;
  logic [DW-1:0] regs_q [8];

  logic          regWe;
  logic [DW-1:0] regWdata;
  logic [6:0]    opcode;
  logic [2:0]    dr, sa, sb;
  logic [DW-1:0] aVal, bVal, immVal, addB, aluRes;
  logic [DW:0]   sum;
  logic          addCin, isArith, isAlu, carryIntoMsb, cFlag, vFlag;
  logic [AW-1:0] aAddr, adVal, pcInc;

  assign opcode = ir_q[15:9];
  assign dr     = ir_q[8:6];
  assign sa     = ir_q[5:3];
  assign sb     = ir_q[2:0];
  assign aVal   = regs_q[sa];
  assign bVal   = regs_q[sb];
  assign immVal = DW'(ir_q[2:0]);
  assign adVal  = AW'($signed({ir_q[8:6], ir_q[2:0]}));
  assign pcInc  = pc_q + AW'(1);

  if (AW > DW) begin : g_addrWide
    assign aAddr = {{(AW-DW){1'b0}}, aVal};
  end else begin : g_addrNarrow
    assign aAddr = aVal[AW-1:0];
  end

  // Subtraction-style ops feed the shared adder with an inverted operand and carry-in.
  always_comb begin
    addB    = '0;
    addCin  = 1'b0;
    isArith = 1'b0;
    isAlu   = 1'b1;
    aluRes  = '0;
    case (opcode)
      OP_MOVA: aluRes = aVal;
      OP_INC:  begin addCin = 1'b1; isArith = 1'b1; end
      OP_ADD:  begin addB = bVal; isArith = 1'b1; end
      OP_SUB:  begin addB = ~bVal; addCin = 1'b1; isArith = 1'b1; end
      OP_DEC:  begin addB = ~DW'(1); addCin = 1'b1; isArith = 1'b1; end
      OP_AND:  aluRes = aVal & bVal;
      OP_OR:   aluRes = aVal | bVal;
      OP_XOR:  aluRes = aVal ^ bVal;
      OP_NOT:  aluRes = ~aVal;
      OP_MOVB: aluRes = bVal;
      OP_SHR:  aluRes = bVal >> 1;
      OP_SHL:  aluRes = bVal << 1;
      OP_LDI:  aluRes = immVal;
      OP_ADI:  begin addB = immVal; isArith = 1'b1; end
      default: isAlu = 1'b0;
    endcase
    sum = {1'b0, aVal} + {1'b0, addB} + {{DW{1'b0}}, addCin};
    if (isArith) aluRes = sum[DW-1:0];
    carryIntoMsb = sum[DW-1] ^ aVal[DW-1] ^ addB[DW-1];
    cFlag = isArith & sum[DW];
    vFlag = isArith & (carryIntoMsb ^ sum[DW]);
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    flags_d  = flags_q;
    regWe    = 1'b0;
    regWdata = aluRes;
    case (state_q)
      S_FETCH: if (ir_valid) begin
        ir_d    = IR;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pcInc;
        if (isAlu) begin
          regWe   = 1'b1;
          flags_d = {vFlag, cFlag, aluRes[DW-1], (aluRes == '0)};
        end else begin
          case (opcode)
            OP_LD, OP_ST: begin state_d = S_MEM; pc_d = pc_q; end
            OP_BRZ:  if (aVal == '0) pc_d = pc_q + adVal;
            OP_BRN:  if (aVal[DW-1]) pc_d = pc_q + adVal;
            OP_JMP:  pc_d = aAddr;
            OP_HALT: begin state_d = S_HALT; pc_d = pc_q; end
            default: ;
          endcase
        end
      end
      S_MEM: if (mem_ack) begin
        state_d = S_FETCH;
        pc_d    = pcInc;
        if (opcode == OP_LD) begin
          regWe    = 1'b1;
          regWdata = Data_in;
        end
      end
      S_HALT:  ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      flags_q <= '0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      if (regWe) regs_q[dr] <= regWdata;
    end
  end

  // Memory-side outputs derive from the state register so an async reset drops them at once.
  assign mem_req     = (state_q == S_MEM);
  assign MW          = mem_req && (opcode == OP_ST);
  assign Address_out = mem_req ? aAddr : '0;
  assign Data_out    = MW ? bVal : '0;
  assign PC          = pc_q;
  assign flags       = flags_q;
  assign halted      = (state_q == S_HALT);
endmodule
